regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the CPU `register_file` single write port. It shares the port between up to four result producers (ALU, load unit, CSR, multiplier) using a valid/ready handshake and registers the winning write onto `wr_ena`/`wr_addr`/`wr_data`. It also keeps a 32-bit busy scoreboard of registers with an outstanding write, which issue logic uses to stall on RAW/WAW hazards. It sits between the execute/memory stages and `register_file`.

## Interface
- `NREQ`, default 2: number of requesters; legal range 1..4.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `req_valid`  input  NREQ  requester i has a write pending.
- `req_ready`  output  NREQ  grant to requester i this cycle; combinational.
- `req_addr`  input  5*NREQ  destination register of requester i, bits [5i+4:5i].
- `req_data`  input  32*NREQ  write data of requester i, bits [32i+31:32i].
- `rsv_ena`  input  1  issue logic reserves a destination register this cycle.
- `rsv_addr`  input  5  register being reserved.
- `busy`  output  32  scoreboard; bit r set means a write to xr is outstanding.
- `wr_ena`  output  1  to `register_file.wr_ena`.
- `wr_addr`  output  5  to `register_file.wr_addr`.
- `wr_data`  output  32  to `register_file.wr_data`.

## Operation
- Handshake: a transfer occurs in a cycle where `req_valid[i] & req_ready[i]`. A requester holds valid, addr and data stable until the transfer. At most one `req_ready` bit is high per cycle. `req_ready[i]` is never high while `req_valid[i]` is low.
- Arbitration: round-robin. Pointer `prio` (0..NREQ-1) is the highest-priority index. Search `prio`, `prio+1`, ... mod NREQ and grant the first valid requester. After a grant to i, `prio` = (i+1) mod NREQ. With no grant, `prio` is unchanged.
- Write stage: a one-entry output register. A transfer at cycle t loads `wr_addr`/`wr_data` and sets `wr_ena`=1 for cycle t+1 only. With no transfer, `wr_ena`=0 and `wr_addr`/`wr_data` hold their last values.
- x0: writes to x0 are granted normally. `wr_ena` stays 0 for that write. `busy[0]` is constant 0 and `rsv_addr`=0 is ignored.
- Scoreboard:
  - `rsv_ena` sets `busy[rsv_addr]` on the next edge.
  - A cycle with `wr_ena`=1 clears `busy[wr_addr]` on the same edge where `register_file` captures the data.
  - Reserve and clear of the same register in the same cycle: reserve wins, so the bit stays 1.
  - A reserve of an already-busy register keeps it at 1. The scoreboard does not count nested reservations; issue logic must not reserve a busy register.
- The register file never stalls. The arbiter accepts one write every cycle with no back-pressure beyond arbitration.

## Timing
- Reset (`rst`=0 at an edge) forces `prio`=0, `wr_ena`=0, `wr_addr`=0, `wr_data`=0, `busy`=0. `req_ready` is 0 while `rst` is low.
- Reset during an outstanding write drops that write; `wr_ena` is 0 in the following cycle.
- Latency from transfer at cycle t:
  - `wr_ena` is high during t+1.
  - The register value is readable through `rd_data*` from cycle t+2.
  - The `busy` bit reads 0 from t+2.
- Throughput: one write per cycle sustained. With k requesters continuously valid, each is granted once every k cycles.
- `req_ready` depends combinationally on `req_valid` and `prio`. Requesters must not drive `req_valid` combinationally from `req_ready`.

## Configuration
- `REGFILE_WB_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest index always wins, and the `prio` register and its update logic are compiled out.
  - Undefined (default): round-robin as described above.
  - Handshake, write stage and scoreboard are identical in both modes.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with all inputs active -> `req_ready`=0, `wr_ena`=0, `wr_addr`=0, `wr_data`=0, `busy`=0.
- Single write: req0 valid, addr 5, data 0xDEADBEEF at cycle t -> `req_ready[0]`=1 at t; `wr_ena`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF at t+1; `wr_ena`=0 at t+2.
- Round-robin, NREQ=2, both valid for 4 cycles (req0 addr 1, req1 addr 2) -> grant order 0,1,0,1; `wr_addr` sequence 1,2,1,2. With `REGFILE_WB_FIXED_PRIO_EN` -> 0,0,0,0 and req1 is never granted.
- x0 drop: req1 writes addr 0, data 0x12345678 -> handshake completes; `wr_ena` stays 0; `busy[0]`=0.
- Scoreboard: `rsv_ena` with addr 7 at cycle t -> `busy[7]`=1 from t+1. Write to x7 transferred at t+3 -> `busy[7]`=0 from t+5.
- Reserve/clear collision: `wr_ena`=1 with `wr_addr`=9 while `rsv_ena`=1 with `rsv_addr`=9 -> `busy[9]` remains 1. Reset asserted mid-write -> `busy`=0 and no `wr_ena` pulse afterwards.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter + busy scoreboard for the single register_file write port; winner registered to wr_* one cycle after transfer.
// No back-pressure beyond arbitration (one write per cycle); REGFILE_WB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module regfile_wb_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic                 rsv_ena,
  input  logic [4:0]           rsv_addr,
  output logic [31:0]          busy,
  output logic                 wr_ena,
  output logic [4:0]           wr_addr,
  output logic [31:0]          wr_data
);

  logic        gnt_any;
  logic [1:0]  gnt_idx;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic [31:0] busy_nxt;

`ifdef REGFILE_WB_FIXED_PRIO_EN

  // Descending scan so the lowest valid index is the last (winning) assignment.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rst && req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = 2'(k);
      end
    end
  end

`else

  logic [1:0] prio;
  logic [2:0] cand;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand = 3'(prio) + 3'(k);
      if (cand >= 3'(NREQ)) begin
        cand = cand - 3'(NREQ);
      end
      for (int j = 0; j < NREQ; j++) begin
        if (rst && !gnt_any && (cand == 3'(j)) && req_valid[j]) begin
          gnt_any = 1'b1;
          gnt_idx = 2'(j);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio <= 2'd0;
    end else if (gnt_any) begin
      prio <= (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
    end
  end

`endif

  always_comb begin
    req_ready = '0;
    sel_addr  = 5'd0;
    sel_data  = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_any && (gnt_idx == 2'(i))) begin
        req_ready[i] = 1'b1;
        sel_addr     = req_addr[i*5 +: 5];
        sel_data     = req_data[i*32 +: 32];
      end
    end
  end

  // x0 writes complete the handshake but never reach the register file.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ena  <= 1'b0;
      wr_addr <= 5'd0;
      wr_data <= 32'd0;
    end else begin
      wr_ena <= gnt_any && (sel_addr != 5'd0);
      if (gnt_any) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

  // Reserve is applied after the clear so a same-cycle collision stays busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_ena) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (rsv_ena) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule
